serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial N-bit subtractor computing `d = a - b` one bit per clock, LSB first, with a single borrow flip-flop and a start/done handshake. It is the subtraction counterpart of the parallel `nbitadder`. It trades latency for area in non-critical ALU paths, such as multi-cycle compare and decrement operations in the RISC datapath.

## Interface
Parameters:
- `N`, default 32: operand and result width; legal range 2..64.

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low; one clock domain only.
- `start` input 1: request a subtraction; sampled only in IDLE.
- `a` input N: minuend; captured on the edge that accepts `start`.
- `b` input N: subtrahend; captured on the same edge as `a`.
- `busy` output 1: high in RUN and DONE.
- `done` output 1: single-cycle pulse, high in DONE.
- `d` output N: difference `a - b` mod 2^N; registered.
- `borrow` output 1: unsigned `a < b`.
- `zero` output 1: `d == 0`.
- `ovf` output 1: signed two's-complement overflow.

## Operation
- FSM with three states, IDLE, RUN and DONE, encoded in 2 bits.
- **IDLE → RUN:** on an edge with `start=1`.
  - Load shift registers `sa<=a` and `sb<=b`.
  - Clear `br` to 0 and `cnt` to 0.
  - Preset the zero accumulator to 1.
- **RUN, each edge:**
  - `x = sa[0] ^ sb[0]`.
  - `diff = x ^ br`.
  - `br_next = (~sa[0] & sb[0]) | (~x & br)`.
  - Shift `diff` into the result register from the MSB side.
  - Shift `sa` and `sb` right by 1.
  - Increment `cnt`.
  - `cnt` is `$clog2(N)` bits wide and never wraps past N-1.
- **RUN → DONE:** on the edge where `cnt == N-1`. That edge processes bit N-1, so after it `d` holds the full result.
- **DONE → IDLE:** unconditionally on the next edge.
- `d` is held from the DONE entry until the next accepted `start`. The result register drives `d` directly, and `d` is not cleared on return to IDLE.
- `start` is ignored in RUN and DONE. The `a` and `b` inputs are don't-care except on the accepting edge.
- Flags are valid from DONE entry and held with `d`:
  - `borrow`: the final `br` after bit N-1.
  - `zero`: AND of `~diff` across all N bits.
  - `ovf`: `(a[N-1] ^ b[N-1]) & (diff[N-1] ^ a[N-1])`, using the MSB operand bits seen at bit N-1.

## Timing
- Reset value of every output: `busy=0`, `done=0`, `d=0`, `borrow=0`, `zero=0`, `ovf=0`. State resets to IDLE.
- Latency, with `start` accepted at edge 0:
  - Edges 1..N process bits 0..N-1.
  - `done` and the valid result appear after edge N.
  - `done` is high for exactly one cycle, the cycle between edges N and N+1.
  - Back at IDLE after edge N+1.
- Throughput: one operation per N+2 cycles at best. `start` held high continuously is accepted again on the first edge in IDLE.
- Reset mid-operation, in RUN or DONE: the FSM returns immediately to IDLE and all outputs go to their reset values. Any partial result is discarded and no `done` is emitted.
- `start` and reset deassertion in the same cycle: no operation is accepted. `start` must be sampled high on an edge with `rst_n=1`.

## Configuration
- Macro `SERIAL_SUB_FLAGS_EN`.
- Defined: the `borrow`, `zero` and `ovf` logic is compiled in, as described under Operation.
- Undefined: the flag logic and the zero and MSB tracking registers are removed.
  - The `borrow`, `zero` and `ovf` ports remain but are tied to 0.
  - `d`, `done`, `busy` and latency are unchanged.

## Test plan
- N=32, a=5, b=3, start pulse → `done` high exactly N=32 edges after acceptance, `d=2`, borrow=0, zero=0, ovf=0 (flags with macro defined).
- a=3, b=5 → `d=0xFFFFFFFE`, borrow=1, zero=0, ovf=0. a=b=0x1234ABCD → `d=0`, zero=1, borrow=0.
- a=0x80000000, b=1 → `d=0x7FFFFFFF`, ovf=1, borrow=0. a=0x7FFFFFFF, b=0xFFFFFFFF → `d=0x80000000`, ovf=1, borrow=1.
- `start` pulsed with a=9, b=4, then `start` again at RUN cycle 10 with a=1, b=1 → second request ignored; `d=5`; exactly one `done` pulse.
- `rst_n` low at RUN cycle 7 of a=100, b=1 → all outputs 0 and IDLE immediately; no `done`. A new start with a=100, b=1 yields `d=99`.
- N=8 build without `SERIAL_SUB_FLAGS_EN`, a=0x10, b=0x20 → `d=0xF0` after 8 edges; borrow, zero and ovf stay 0 throughout.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (d = a - b), LSB first, with start/done handshake.
// Optional macro SERIAL_SUB_FLAGS_EN compiles in the borrow/zero/ovf flag logic.
module serial_subtractor #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] d,
  output logic         borrow,
  output logic         zero,
  output logic         ovf
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  logic          br;
  logic [CW-1:0] cnt;
  logic          x;
  logic          diff;
  logic          br_next;

  assign x       = sa[0] ^ sb[0];
  assign diff    = x ^ br;
  assign br_next = (~sa[0] & sb[0]) | (~x & br);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      d     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          // Result fills from the MSB side, so after N shifts bit 0 sits at d[0].
          d  <= {diff, d[N-1:1]};
          sa <= sa >> 1;
          sb <= sb >> 1;
          br <= br_next;
          if (cnt == LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  logic zacc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zacc   <= 1'b0;
      borrow <= 1'b0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == IDLE && start) begin
      zacc <= 1'b1;
    end else if (state == RUN) begin
      zacc <= zacc & ~diff;
      // On the last bit sa[0]/sb[0] are the operand MSBs, so ovf needs no extra tracking.
      if (cnt == LAST) begin
        borrow <= br_next;
        zero   <= zacc & ~diff;
        ovf    <= x & (diff ^ sa[0]);
      end
    end
  end
`else
  assign borrow = 1'b0;
  assign zero   = 1'b0;
  assign ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, random ops vs arithmetic model,
// ignored-start, mid-run reset and an N=8 instance.
module tb_serial_subtractor;
  localparam int N = 32;
`ifdef SERIAL_SUB_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, borrow, zero, ovf;
  logic [N-1:0] d;

  logic         start8 = 1'b0;
  logic [7:0]   a8 = '0;
  logic [7:0]   b8 = '0;
  logic         busy8, done8, borrow8, zero8, ovf8;
  logic [7:0]   d8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .borrow(borrow), .zero(zero), .ovf(ovf)
  );

  serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .d(d8), .borrow(borrow8), .zero(zero8), .ovf(ovf8)
  );

  typedef struct {
    logic [N-1:0] va;
    logic [N-1:0] vb;
    logic [N-1:0] ed;
    logic         eb;
    logic         ez;
    logic         eo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  // Full operation: latency, result, flags and the one-cycle done pulse.
  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                       input logic [N-1:0] ed, input logic eb, input logic ez,
                       input logic eo, input string nm);
    int  edges;
    bit  seen;
    @(negedge clk);
    chk({nm, "_idle"}, {63'd0, busy}, 64'd0);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    edges = 0; seen = 1'b0;
    while (!seen && edges < N + 5) begin
      @(posedge clk); #1;
      edges++;
      if (done) seen = 1'b1;
    end
    chk({nm, "_latency"}, 64'(edges), 64'(N));
    chk({nm, "_d"}, 64'(d), 64'(ed));
    chk({nm, "_flags"}, {61'd0, borrow, zero, ovf}, {61'd0, eb & FL, ez & FL, eo & FL});
    @(posedge clk); #1;
    chk({nm, "_pulse_end"}, {62'd0, done, busy}, 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    logic [N-1:0] ra, rb, rd;
    int           dones;

    vecs[0] = '{32'd5,        32'd3,        32'd2,          1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'd3,        32'd5,        32'hFFFFFFFE,   1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h1234ABCD, 32'h1234ABCD, 32'd0,          1'b0, 1'b1, 1'b0};
    vecs[3] = '{32'h80000000, 32'd1,        32'h7FFFFFFF,   1'b0, 1'b0, 1'b1};
    vecs[4] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000,   1'b1, 1'b0, 1'b1};

    #12;
    chk("reset_outs", {28'd0, busy, done, borrow, zero, ovf, d}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      do_op(vecs[i].va, vecs[i].vb, vecs[i].ed, vecs[i].eb, vecs[i].ez, vecs[i].eo,
            $sformatf("vec%0d", i));

    // Random operations against plain arithmetic.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom;
      if (i == 3) rb = ra;
      rd = ra - rb;
      do_op(ra, rb, rd, (ra < rb), (rd == '0),
            (ra[N-1] != rb[N-1]) && (rd[N-1] != ra[N-1]), $sformatf("rnd%0d", i));
    end

    // Second start during RUN must be ignored.
    @(negedge clk);
    a = 32'd9; b = 32'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    dones = 0;
    for (int e = 1; e <= N + 4; e++) begin
      @(posedge clk); #1;
      if (e == 10) begin a = 32'd1; b = 32'd1; start = 1'b1; end
      if (e == 11) start = 1'b0;
      if (done) dones++;
    end
    chk("ignored_start_d", 64'(d), 64'd5);
    chk("ignored_start_dones", 64'(dones), 64'd1);

    // Reset at RUN cycle 7 discards the operation.
    @(negedge clk);
    a = 32'd100; b = 32'd1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrun_reset_outs", {28'd0, busy, done, borrow, zero, ovf, d}, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int e = 0; e < N + 4; e++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("midrun_reset_no_done", 64'(dones), 64'd0);
    do_op(32'd100, 32'd1, 32'd99, 1'b0, 1'b0, 1'b0, "after_reset");

    // N=8 instance.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
    @(posedge clk); #1 start8 = 1'b0;
    dones = 0;
    begin
      int edges;
      edges = 0;
      while (dones == 0 && edges < 16) begin
        @(posedge clk); #1;
        edges++;
        if (done8) dones++;
      end
      chk("n8_latency", 64'(edges), 64'd8);
    end
    chk("n8_d", 64'(d8), 64'hF0);
    chk("n8_flags", {61'd0, borrow8, zero8, ovf8}, {61'd0, FL, 1'b0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
